tlb_op_ctrl: RTL and testbench

Sequencer and port arbiter for the 16-entry TLB in the MMU. Executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB issued by the writeback/CSR stage, one at a time, via the TLB's write, read, lookup port 1 and invalidate inputs. Arbitrates lookup port 1 between these operations and ordinary load/store translation. Owns the round-robin TLBFILL victim counter.

---
 rtl/tlb_pkg.sv | 47 ++++
 rtl/tlb_op_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared TLB constants, op codes and packed-entry field layout
package tlb_pkg;

  localparam int TLBNUM  = 16;
  localparam int IW      = $clog2(TLBNUM);
  localparam int ENTRY_W = 89;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [4:0] INV_OP_MAX = 5'd6;

  // Entry layout, msb first: {e, vppn, ps, asid, g, lo0, lo1}
  localparam int LO_W     = 26;
  localparam int LO1_LSB  = 0;
  localparam int LO0_LSB  = 26;
  localparam int G_BIT    = 52;
  localparam int ASID_LSB = 53;
  localparam int ASID_W   = 10;
  localparam int PS_LSB   = 63;
  localparam int PS_W     = 6;
  localparam int VPPN_LSB = 69;
  localparam int VPPN_W   = 19;
  localparam int E_BIT    = 88;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;
  localparam logic [PS_W-1:0] PS_4M = 6'd22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic logic [ENTRY_W-1:0] entry_with_e(input logic [ENTRY_W-1:0] ent,
                                                      input logic e);
    logic [ENTRY_W-1:0] r;
    r        = ent;
    r[E_BIT] = e;
    return r;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// rtl/tlb_op_ctrl.sv - TLB maintenance-op sequencer, port-1 arbiter and FILL victim counter
module tlb_op_ctrl
  import tlb_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [2:0]         op_code,
  input  logic [IW-1:0]      op_index,
  input  logic [ENTRY_W-1:0] op_entry,
  input  logic               op_ne,
  input  logic               op_refill,
  input  logic [4:0]         inv_op,
  input  logic [9:0]         inv_asid,
  input  logic [31:0]        inv_va,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [IW-1:0]      rsp_index,
  output logic [ENTRY_W-1:0] rsp_entry,
  output logic               rsp_err,
  input  logic [18:0]        mem_s1_vppn,
  input  logic               mem_s1_va_bit12,
  input  logic [9:0]         mem_s1_asid,
  output logic               mem_s1_gnt,
  output logic [18:0]        tlb_s1_vppn,
  output logic               tlb_s1_va_bit12,
  output logic [9:0]         tlb_s1_asid,
  input  logic               tlb_s1_found,
  input  logic [IW-1:0]      tlb_s1_index,
  output logic               tlb_invtlb_valid,
  output logic [4:0]         tlb_invtlb_op,
  output logic               tlb_we,
  output logic [IW-1:0]      tlb_w_index,
  output logic [ENTRY_W-1:0] tlb_w_entry,
  output logic [IW-1:0]      tlb_r_index,
  input  logic [ENTRY_W-1:0] tlb_r_entry
);

  state_e               state_q, state_d;
  logic [2:0]           op_code_q, op_code_d;
  logic [IW-1:0]        op_index_q, op_index_d;
  logic [ENTRY_W-1:0]   op_entry_q, op_entry_d;
  logic                 op_ne_q, op_ne_d;
  logic                 op_refill_q, op_refill_d;
  logic [4:0]           inv_op_q, inv_op_d;
  logic [9:0]           inv_asid_q, inv_asid_d;
  logic [31:0]          inv_va_q, inv_va_d;
  logic [IW-1:0]        fill_cnt_q, fill_cnt_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic [IW-1:0]        rsp_index_q, rsp_index_d;
  logic [ENTRY_W-1:0]   rsp_entry_q, rsp_entry_d;
  logic                 rsp_err_q, rsp_err_d;

  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_index_q;
  assign rsp_entry = rsp_entry_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    op_code_d   = op_code_q;
    op_index_d  = op_index_q;
    op_entry_d  = op_entry_q;
    op_ne_d     = op_ne_q;
    op_refill_d = op_refill_q;
    inv_op_d    = inv_op_q;
    inv_asid_d  = inv_asid_q;
    inv_va_d    = inv_va_q;
    fill_cnt_d  = fill_cnt_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_entry_d = rsp_entry_q;
    rsp_err_d   = rsp_err_q;

    op_ready         = 1'b0;
    rsp_valid        = 1'b0;
    mem_s1_gnt       = 1'b1;
    tlb_s1_vppn      = mem_s1_vppn;
    tlb_s1_va_bit12  = mem_s1_va_bit12;
    tlb_s1_asid      = mem_s1_asid;
    tlb_we           = 1'b0;
    tlb_invtlb_valid = 1'b0;
    tlb_invtlb_op    = inv_op_q;
    tlb_w_index      = (op_code_q == OP_FILL) ? fill_cnt_q : op_index_q;
    tlb_w_entry      = entry_with_e(op_entry_q, op_refill_q | ~op_ne_q);
    tlb_r_index      = op_index_q;

    case (state_q)
      ST_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          op_code_d   = op_code;
          op_index_d  = op_index;
          op_entry_d  = op_entry;
          op_ne_d     = op_ne;
          op_refill_d = op_refill;
          inv_op_d    = inv_op;
          inv_asid_d  = inv_asid;
          inv_va_d    = inv_va;
          rsp_hit_d   = 1'b0;
          rsp_index_d = '0;
          rsp_entry_d = '0;
          rsp_err_d   = 1'b0;
          case (op_code)
            OP_SRCH, OP_RD: state_d = ST_LOOKUP;
            OP_WR, OP_FILL: state_d = ST_WRITE;
            OP_INV: begin
              if (inv_op <= INV_OP_MAX) begin
                state_d = ST_WRITE;
              end else begin
                state_d   = ST_RESP;
                rsp_err_d = 1'b1;
              end
            end
            default: begin
              state_d   = ST_RESP;
              rsp_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_LOOKUP: begin
        if (op_code_q == OP_SRCH) begin
          mem_s1_gnt      = 1'b0;
          tlb_s1_vppn     = op_entry_q[VPPN_LSB +: VPPN_W];
          tlb_s1_va_bit12 = 1'b0;
          tlb_s1_asid     = op_entry_q[ASID_LSB +: ASID_W];
          rsp_hit_d       = tlb_s1_found;
          rsp_index_d     = tlb_s1_index;
        end else begin
          rsp_entry_d = tlb_r_entry;
        end
        state_d = ST_RESP;
      end
      ST_WRITE: begin
        // Gated by resetn so an op abandoned by reset never reaches the TLB.
        if (op_code_q == OP_INV) begin
          mem_s1_gnt       = 1'b0;
          tlb_invtlb_valid = resetn;
          tlb_s1_vppn      = inv_va_q[31:13];
          tlb_s1_va_bit12  = inv_va_q[12];
          tlb_s1_asid      = inv_asid_q;
        end else begin
          tlb_we = resetn;
          if (op_code_q == OP_FILL) begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      op_code_q   <= '0;
      op_index_q  <= '0;
      op_entry_q  <= '0;
      op_ne_q     <= 1'b0;
      op_refill_q <= 1'b0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_va_q    <= '0;
      fill_cnt_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_entry_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_code_q   <= op_code_d;
      op_index_q  <= op_index_d;
      op_entry_q  <= op_entry_d;
      op_ne_q     <= op_ne_d;
      op_refill_q <= op_refill_d;
      inv_op_q    <= inv_op_d;
      inv_asid_q  <= inv_asid_d;
      inv_va_q    <= inv_va_d;
      fill_cnt_q  <= fill_cnt_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_entry_q <= rsp_entry_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb/tb_tlb_op_ctrl.sv - directed scoreboard bench for tlb_op_ctrl with a behavioural 16-entry TLB
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid, op_ready;
  logic [2:0]  op_code;
  logic [3:0]  op_index;
  logic [88:0] op_entry;
  logic        op_ne, op_refill;
  logic [4:0]  inv_op;
  logic [9:0]  inv_asid;
  logic [31:0] inv_va;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_err;
  logic [3:0]  rsp_index;
  logic [88:0] rsp_entry;
  logic [18:0] mem_s1_vppn;
  logic        mem_s1_va_bit12;
  logic [9:0]  mem_s1_asid;
  logic        mem_s1_gnt;
  logic [18:0] tlb_s1_vppn;
  logic        tlb_s1_va_bit12;
  logic [9:0]  tlb_s1_asid;
  logic        tlb_s1_found;
  logic [3:0]  tlb_s1_index;
  logic        tlb_invtlb_valid;
  logic [4:0]  tlb_invtlb_op;
  logic        tlb_we;
  logic [3:0]  tlb_w_index;
  logic [88:0] tlb_w_entry;
  logic [3:0]  tlb_r_index;
  logic [88:0] tlb_r_entry;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_index(op_index),
    .op_entry(op_entry), .op_ne(op_ne), .op_refill(op_refill),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_va(inv_va),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_index(rsp_index),
    .rsp_entry(rsp_entry), .rsp_err(rsp_err),
    .mem_s1_vppn(mem_s1_vppn), .mem_s1_va_bit12(mem_s1_va_bit12), .mem_s1_asid(mem_s1_asid),
    .mem_s1_gnt(mem_s1_gnt),
    .tlb_s1_vppn(tlb_s1_vppn), .tlb_s1_va_bit12(tlb_s1_va_bit12), .tlb_s1_asid(tlb_s1_asid),
    .tlb_s1_found(tlb_s1_found), .tlb_s1_index(tlb_s1_index),
    .tlb_invtlb_valid(tlb_invtlb_valid), .tlb_invtlb_op(tlb_invtlb_op),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry)
  );

  // Behavioural TLB on the far side of the ports.
  logic [88:0] model [16];
  logic        model_init;

  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 16; i++) model[i] <= '0;
    end else begin
      if (tlb_we) model[tlb_w_index] <= tlb_w_entry;
      if (tlb_invtlb_valid && tlb_invtlb_op == 5'd5) begin
        for (int i = 0; i < 16; i++)
          if (!model[i][52] && model[i][62:53] == tlb_s1_asid && model[i][87:69] == tlb_s1_vppn)
            model[i] <= '0;
      end
    end
  end

  always_comb begin
    tlb_s1_found = 1'b0;
    tlb_s1_index = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (model[i][88] && model[i][87:69] == tlb_s1_vppn &&
          (model[i][52] || model[i][62:53] == tlb_s1_asid)) begin
        tlb_s1_found = 1'b1;
        tlb_s1_index = 4'(i);
      end
    end
  end

  assign tlb_r_entry = model[tlb_r_index];

  typedef struct {
    logic        err;
    logic        chk_hit;
    logic        hit;
    logic [3:0]  idx;
    logic        chk_ent;
    logic [88:0] ent;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
                                           input logic [5:0] ps, input logic [9:0] asid,
                                           input logic g, input logic [25:0] lo0,
                                           input logic [25:0] lo1);
    return {e, vppn, ps, asid, g, lo0, lo1};
  endfunction

  task automatic do_op(input logic [2:0] code, input logic [3:0] idx, input logic [88:0] ent,
                       input logic ne, input logic refill, input logic [4:0] iop,
                       input logic [9:0] iasid, input logic [31:0] iva,
                       input int exp_lat, input int exp_we, input logic [3:0] exp_widx,
                       input logic [88:0] exp_went, input int exp_inv, input exp_t e,
                       input int hold);
    int   lat, we_cnt, inv_cnt;
    logic got, exp_gnt;
    exp_t x;
    sbq.push_back(e);
    @(negedge clk);
    chk("op_ready_before_issue", op_ready, 1'b1);
    op_code = code; op_index = idx; op_entry = ent; op_ne = ne; op_refill = refill;
    inv_op = iop; inv_asid = iasid; inv_va = iva; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = 0; we_cnt = 0; inv_cnt = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (tlb_we) begin
        we_cnt++;
        chk("w_index", tlb_w_index, exp_widx);
        chk("w_entry", tlb_w_entry, exp_went);
      end
      if (tlb_invtlb_valid) begin
        inv_cnt++;
        chk("invtlb_op", tlb_invtlb_op, iop);
      end
      exp_gnt = !(lat == 1 && exp_lat == 2 && (code == 3'd0 || code == 3'd4));
      chk("mem_s1_gnt", mem_s1_gnt, exp_gnt);
      if (exp_gnt) chk("s1_vppn_mem", tlb_s1_vppn, mem_s1_vppn);
      else chk("s1_vppn_op", tlb_s1_vppn, (code == 3'd0) ? ent[87:69] : iva[31:13]);
      if (rsp_valid) got = 1'b1;
    end
    chk("latency", lat, exp_lat);
    chk("we_pulses", we_cnt, exp_we);
    chk("invtlb_pulses", inv_cnt, exp_inv);
    x = sbq.pop_front();
    if (got) begin
      chk("rsp_err", rsp_err, x.err);
      if (x.chk_hit) begin
        chk("rsp_hit", rsp_hit, x.hit);
        chk("rsp_index", rsp_index, x.idx);
      end
      if (x.chk_ent) chk("rsp_entry", rsp_entry, x.ent);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_rsp_valid", rsp_valid, 1'b1);
        chk("hold_op_ready", op_ready, 1'b0);
        chk("hold_rsp_err", rsp_err, x.err);
        if (x.chk_ent) chk("hold_rsp_entry", rsp_entry, x.ent);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  exp_t        e_none, e_err, e_s;
  logic [88:0] wr_ent, wr_exp, f_ent;

  initial begin
    resetn = 1'b0; model_init = 1'b1;
    op_valid = 1'b0; op_code = '0; op_index = '0; op_entry = '0; op_ne = 1'b0; op_refill = 1'b0;
    inv_op = '0; inv_asid = '0; inv_va = '0; rsp_ready = 1'b0;
    mem_s1_vppn = 19'h7ABCD; mem_s1_va_bit12 = 1'b1; mem_s1_asid = 10'h2A;
    e_none = '{err: 1'b0, chk_hit: 1'b0, hit: 1'b0, idx: 4'd0, chk_ent: 1'b0, ent: '0};
    e_err  = '{err: 1'b1, chk_hit: 1'b0, hit: 1'b0, idx: 4'd0, chk_ent: 1'b0, ent: '0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1; model_init = 1'b0;
    @(negedge clk);
    chk("reset_op_ready", op_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_tlb_we", tlb_we, 1'b0);
    chk("reset_invtlb", tlb_invtlb_valid, 1'b0);
    chk("reset_gnt", mem_s1_gnt, 1'b1);
    chk("reset_rsp_hit", rsp_hit, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_s1_vppn", tlb_s1_vppn, 19'h7ABCD);

    for (int i = 0; i < 3; i++) begin
      f_ent = mk_entry(1'b0, 19'h40000 + 19'(i), 6'd12, 10'h7, 1'b0, 26'h1000 + 26'(i), 26'h2000);
      do_op(3'd3, 4'd9, f_ent, 1'b1, 1'b1, 5'd0, 10'd0, 32'd0,
            2, 1, 4'(i), {1'b1, f_ent[87:0]}, 0, e_none, 0);
    end

    wr_ent = mk_entry(1'b0, 19'h00123, 6'd12, 10'h3, 1'b0, 26'h0ABCDE, 26'h1234567);
    wr_exp = {1'b1, wr_ent[87:0]};
    do_op(3'd2, 4'd5, wr_ent, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 2, 1, 4'd5, wr_exp, 0, e_none, 0);

    f_ent = mk_entry(1'b1, 19'h05555, 6'd22, 10'h3, 1'b0, 26'h1, 26'h2);
    do_op(3'd2, 4'd9, f_ent, 1'b1, 1'b0, 5'd0, 10'd0, 32'd0,
          2, 1, 4'd9, {1'b0, f_ent[87:0]}, 0, e_none, 0);

    e_s = '{err: 1'b0, chk_hit: 1'b1, hit: 1'b1, idx: 4'd5, chk_ent: 1'b0, ent: '0};
    do_op(3'd0, 4'd0, wr_ent, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 2, 0, 4'd0, '0, 0, e_s, 0);

    e_s = '{err: 1'b0, chk_hit: 1'b1, hit: 1'b0, idx: 4'd0, chk_ent: 1'b0, ent: '0};
    do_op(3'd0, 4'd0, f_ent, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 2, 0, 4'd0, '0, 0, e_s, 0);

    e_s = '{err: 1'b0, chk_hit: 1'b0, hit: 1'b0, idx: 4'd0, chk_ent: 1'b1, ent: wr_exp};
    do_op(3'd1, 4'd5, '0, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 2, 0, 4'd0, '0, 0, e_s, 4);

    do_op(3'd4, 4'd0, '0, 1'b0, 1'b0, 5'd5, 10'h3, 32'h00246000, 2, 0, 4'd0, '0, 1, e_none, 0);

    e_s = '{err: 1'b0, chk_hit: 1'b1, hit: 1'b0, idx: 4'd0, chk_ent: 1'b0, ent: '0};
    do_op(3'd0, 4'd0, wr_ent, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 2, 0, 4'd0, '0, 0, e_s, 0);

    do_op(3'd4, 4'd0, '0, 1'b0, 1'b0, 5'd9, 10'h3, 32'h00246000, 1, 0, 4'd0, '0, 0, e_err, 0);
    do_op(3'd6, 4'd0, '0, 1'b0, 1'b0, 5'd0, 10'd0, 32'd0, 1, 0, 4'd0, '0, 0, e_err, 2);

    for (int i = 0; i < 16; i++) begin
      f_ent = mk_entry(1'b0, 19'h50000 + 19'(i), 6'd12, 10'h7, 1'b0, 26'h3, 26'h4);
      do_op(3'd3, 4'd0, f_ent, 1'b1, 1'b1, 5'd0, 10'd0, 32'd0,
            2, 1, 4'((i + 3) % 16), {1'b1, f_ent[87:0]}, 0, e_none, 0);
    end

    // Reset lands on the WRITE cycle of a FILL.
    @(negedge clk);
    op_code = 3'd3; op_refill = 1'b1; op_ne = 1'b1; op_entry = f_ent; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("we_in_reset_cycle", tlb_we, 1'b0);
    @(negedge clk);
    chk("we_after_reset", tlb_we, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_op_ready", op_ready, 1'b1);
    chk("post_reset_rsp_valid", rsp_valid, 1'b0);
    chk("post_reset_we", tlb_we, 1'b0);
    chk("post_reset_gnt", mem_s1_gnt, 1'b1);
    do_op(3'd3, 4'd0, f_ent, 1'b1, 1'b1, 5'd0, 10'd0, 32'd0,
          2, 1, 4'd0, {1'b1, f_ent[87:0]}, 0, e_none, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
